instr_issue_unit: RTL

Command-side driver for `processor_no_mem`: holds a small program RAM and feeds the core one instruction at a time over its `command`/`run`/`done` interface. It fetches the word addressed by the core's current PC, presents it with a one-cycle `run` pulse, waits for `done`, then fetches again. It halts on `ECALL` or an all-zero word and faults on a bad PC or a hung core. It replaces hand-driven command sequencing in system-level runs.

---
 rtl/instr_issue_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: program RAM plus a small sequencer that feeds a core one
// instruction at a time over a command/run/done handshake. The sequencer
// fetches the word at the core's PC and issues it with a one-cycle run strobe.
// It then waits for done and fetches again. It halts on ECALL or an all-zero
// word, and it faults on a bad PC or a core that never answers.
module instr_issue_unit #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [31:0]       pc_in,
  input  logic              done,
  output logic [31:0]       command,
  output logic              run,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [31:0]       instr_count
);

  localparam logic [31:0]       ECALL_WORD = 32'h0000_0073;
  localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [1:0]        code_q, code_d;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rd_q;
  logic              rd_en;
  logic              load_ok;
  logic              halt_word;
  logic              issue_ok;

  // The RAM may only be rewritten while the sequencer is parked.
  assign load_ok   = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_FAULT);
  assign halt_word = (rd_q == ECALL_WORD) || (rd_q == '0);
  assign issue_ok  = (state_q == S_ISSUE) && !halt_word;

  // The strobe and command come from registers only. During ISSUE the freshly
  // read word is shown directly, so command is valid in the same cycle as run.
  assign run         = issue_ok;
  assign command     = issue_ok ? rd_q : cmd_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign instr_count = cnt_q;

  // Program RAM: gated synchronous write, and a registered read launched in FETCH.
  // NOTE: the RAM array has no reset so it maps onto block RAM; program contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem_q[load_addr] <= load_data;
    end
    if (rd_en) begin
      rd_q <= mem_q[pc_in[ADDR_W+1:2]];
    end
  end

  // State and control registers: asynchronous reset to IDLE with all outputs cleared.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  // Next-state logic: start, fetch checks, issue or halt, and wait with timeout.
  // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    code_d   = code_q;
    rd_en    = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          state_d  = S_FETCH;
          cnt_d    = '0;
          halted_d = 1'b0;
          fault_d  = 1'b0;
          code_d   = '0;
        end
      end

      S_FETCH: begin
        if (pc_in[1:0] != 2'b00) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = FC_MISALIGN;
        end else if (pc_in[31:ADDR_W+2] != '0) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = FC_RANGE;
        end else begin
          rd_en   = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (halt_word) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          cmd_d   = rd_q;
          wait_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // done takes priority over a timeout that expires in the same cycle.
        if (done) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = FC_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
